// File: rtl/p_mul_pkg.sv
// Shared definitions for the packed iterative multiplier:
// pack-width decode, FSM encoding and lane-layout helpers.
package p_mul_pkg;

  localparam int PW_32 = 0;
  localparam int PW_16 = 1;
  localparam int PW_8  = 2;
  localparam int PW_4  = 3;
  localparam int PW_2  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int lane_w(input logic [4:0] pw);
    case (pw)
      5'(1 << PW_32): return 32;
      5'(1 << PW_16): return 16;
      5'(1 << PW_8):  return 8;
      5'(1 << PW_4):  return 4;
      5'(1 << PW_2):  return 2;
      default:        return 0;
    endcase
  endfunction

  function automatic int lane_n(input logic [4:0] pw, input int step);
    int w;
    w = lane_w(pw);
    if (w == 0) return 0;
    return (w > step) ? w / step : 1;
  endfunction

  // Lane i's W bits go to the low half of its 2W-bit accumulator field.
  function automatic logic [63:0] spread(input logic [31:0] v, input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      r[6'((i / w) * 2 * w + (i % w))] = v[i];
    return r;
  endfunction

  function automatic logic [31:0] gather(input logic [63:0] acc,
                                         input int w, input logic hi);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      r[i] = acc[6'((i / w) * 2 * w + (hi ? w : 0) + (i % w))];
    return r;
  endfunction

  function automatic logic [63:0] heads(input int w);
    logic [63:0] r;
    r = '0;
    for (int p = 0; p < 64; p++)
      r[p] = (p % (2 * w)) == 0;
    return r;
  endfunction

  // Broadcast each field-head bit across its whole field.
  function automatic logic [63:0] fill(input logic [63:0] sel,
                                       input logic [63:0] starts);
    logic [63:0] m;
    logic on;
    m  = '0;
    on = 1'b0;
    for (int p = 0; p < 64; p++) begin
      if (starts[p]) on = sel[p];
      m[p] = on;
    end
    return m;
  endfunction

  // Packed adder: carry chain is cut at every field head, and
  // disabled entirely for GF(2) accumulation.
  function automatic logic [63:0] packed_add(input logic [63:0] x,
                                             input logic [63:0] y,
                                             input logic [63:0] starts,
                                             input logic carry_en);
    logic [63:0] s;
    logic c;
    s = '0;
    c = 1'b0;
    for (int p = 0; p < 64; p++) begin
      if (starts[p]) c = 1'b0;
      s[p] = x[p] ^ y[p] ^ c;
      c = carry_en & ((x[p] & y[p]) | (c & (x[p] ^ y[p])));
    end
    return s;
  endfunction

endpackage

// File: rtl/p_mul_step.sv
// One RUN cycle of the packed multiplier: STEP chained
// lane-masked shift-and-add (or XOR) stages.
module p_mul_step
  import p_mul_pkg::*;
#(
  parameter int STEP = 2
) (
  input  logic [63:0] acc,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  step_idx,
  input  logic [4:0]  pw,
  input  logic        clmul,
  output logic [63:0] acc_next
);

  logic [63:0] a_wide;
  logic [63:0] b_wide;
  logic [63:0] starts;
  logic [STEP:0][63:0] chain;
  logic [63:0] sel;
  logic [63:0] mask;
  int k;

  always_comb begin
    a_wide = '0;
    b_wide = '0;
    starts = '0;
    case (lane_w(pw))
      32: begin
        a_wide = spread(a, 32);
        b_wide = spread(b, 32);
        starts = heads(32);
      end
      16: begin
        a_wide = spread(a, 16);
        b_wide = spread(b, 16);
        starts = heads(16);
      end
      8: begin
        a_wide = spread(a, 8);
        b_wide = spread(b, 8);
        starts = heads(8);
      end
      4: begin
        a_wide = spread(a, 4);
        b_wide = spread(b, 4);
        starts = heads(4);
      end
      2: begin
        a_wide = spread(a, 2);
        b_wide = spread(b, 2);
        starts = heads(2);
      end
      default: ;
    endcase
  end

  // Bit k of a lane's multiplier lands on its field head after
  // shifting b_wide; k >= W reads the zero upper half, so it drops out.
  always_comb begin
    chain    = '0;
    sel      = '0;
    mask     = '0;
    k        = 0;
    chain[0] = acc;
    for (int j = 0; j < STEP; j++) begin
      k = int'(step_idx) * STEP + j;
      sel = (b_wide >> k) & starts;
      mask = fill(sel, starts);
      chain[j+1] = packed_add(chain[j], (a_wide << k) & mask,
                              starts, !clmul);
    end
    acc_next = chain[STEP];
  end

endmodule

// File: rtl/p_mul_rn.sv
// Iterative packed integer / carry-less multiplier with
// IDLE/RUN/DONE handshake and abort on valid drop.
module p_mul_rn
  import p_mul_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 2
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            valid,
  output logic            ready,
  input  logic            mul_l,
  input  logic            mul_h,
  input  logic            clmul,
  input  logic [4:0]      pw,
  input  logic [XLEN-1:0] crs1,
  input  logic [XLEN-1:0] crs2,
  output logic [XLEN-1:0] result
);

  state_t state;
  state_t state_nx;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [4:0]  pw_q;
  logic [4:0]  step_q;
  logic        hi_q;
  logic        cl_q;
  logic        last;
  logic [63:0] acc_q;
  logic [63:0] acc_nx;
  logic        unused_mode;

  // mul_h wins over mul_l and neither selects low, so mul_l is moot.
  assign unused_mode = mul_l;

  p_mul_step #(.STEP(STEP)) u_step (
    .acc      (acc_q),
    .a        (a_q),
    .b        (b_q),
    .step_idx (step_q),
    .pw       (pw_q),
    .clmul    (cl_q),
    .acc_next (acc_nx)
  );

  assign last = step_q == 5'(lane_n(pw_q, STEP) - 1);

  always_ff @(posedge clock) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    case (state)
      IDLE: if (valid) state_nx = (lane_w(pw) == 0) ? DONE : RUN;
      RUN: begin
        if (!valid)    state_nx = IDLE;
        else if (last) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
        ready    = valid;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      a_q    <= '0;
      b_q    <= '0;
      pw_q   <= '0;
      hi_q   <= 1'b0;
      cl_q   <= 1'b0;
      acc_q  <= '0;
      step_q <= '0;
    end else begin
      case (state)
        IDLE: if (valid) begin
          a_q    <= crs1;
          b_q    <= crs2;
          pw_q   <= pw;
          hi_q   <= mul_h;
          cl_q   <= clmul;
          acc_q  <= '0;
          step_q <= '0;
        end
        RUN: begin
          if (!valid) begin
            acc_q  <= '0;
            step_q <= '0;
          end else begin
            acc_q  <= acc_nx;
            step_q <= step_q + 5'd1;
          end
        end
        default: begin
          acc_q  <= '0;
          step_q <= '0;
        end
      endcase
    end
  end

  always_comb begin
    result = '0;
    if (ready) begin
      case (lane_w(pw_q))
        32:      result = gather(acc_q, 32, hi_q);
        16:      result = gather(acc_q, 16, hi_q);
        8:       result = gather(acc_q, 8, hi_q);
        4:       result = gather(acc_q, 4, hi_q);
        2:       result = gather(acc_q, 2, hi_q);
        default: result = '0;
      endcase
    end
  end

endmodule
